// File: rtl/div_unit_pkg.sv
// Shared constants, state encoding and sign fix-up helper for the iterative divider.
package div_unit_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam int DIV_CYCLES_DEFAULT = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] val);
    return neg ? (32'd0 - val) : val;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Handshake between exe/pipe_ctrl and the divider.
interface div_unit_if;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        cancel_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        busy_o;
  logic        stallreq_o;

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, cancel_i,
    output result_o, ready_o, busy_o, stallreq_o
  );

  modport master (
    output start_i, op_i, dividend_i, divisor_i, cancel_i,
    input  result_o, ready_o, busy_o, stallreq_o
  );
endinterface

// File: rtl/div_unit.sv
// Restoring RV32M divider: one quotient bit per cycle, sign fix-up on entry to DONE.
//   state    | meaning
//   DIV_IDLE | waiting for start_i; latches magnitudes and sign flags
//   DIV_CALC | one restoring iteration per cycle
//   DIV_DONE | result_o valid, ready_o pulses for one cycle
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input logic        clk_i,
  input logic        rst_i,
  div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      quot_q, quot_d;
  logic [31:0]      dvsr_q, dvsr_d;
  logic             is_rem_q, is_rem_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic [31:0]      result_q, result_d;

  logic        signed_op;
  logic [31:0] abs_a, abs_b;
  logic [32:0] rem_shift, diff;
  logic [31:0] rem_next, quot_next;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    is_rem_d   = is_rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = '0;

    signed_op = ~bus.op_i[0];
    abs_a     = neg_if(signed_op & bus.dividend_i[31], bus.dividend_i);
    abs_b     = neg_if(signed_op & bus.divisor_i[31], bus.divisor_i);

    // Partial remainder stays below the divisor, so bit 32 of the difference is its sign.
    rem_shift = {rem_q, quot_q[31]};
    diff      = rem_shift - {1'b0, dvsr_q};
    rem_next  = diff[32] ? rem_shift[31:0] : diff[31:0];
    quot_next = {quot_q[30:0], ~diff[32]};

    if (bus.cancel_i) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (bus.start_i) begin
            rem_d      = '0;
            quot_d     = abs_a;
            dvsr_d     = abs_b;
            is_rem_d   = bus.op_i[1];
            neg_quot_d = signed_op & (bus.dividend_i[31] ^ bus.divisor_i[31]);
            neg_rem_d  = signed_op & bus.dividend_i[31];
            cnt_d      = '0;
            if (bus.divisor_i == 32'd0) begin
              state_d  = DIV_DONE;
              result_d = bus.op_i[1] ? bus.dividend_i : 32'hFFFF_FFFF;
            end else begin
              state_d  = DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          rem_d  = rem_next;
          quot_d = quot_next;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d  = DIV_DONE;
            result_d = is_rem_q ? neg_if(neg_rem_q, rem_next)
                                : neg_if(neg_quot_q, quot_next);
          end
        end
        DIV_DONE: state_d = DIV_IDLE;
        default:  state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      is_rem_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvsr_q     <= dvsr_d;
      is_rem_q   <= is_rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
    end
  end

  assign bus.result_o   = result_q;
  assign bus.ready_o    = (state_q == DIV_DONE);
  assign bus.busy_o     = (state_q == DIV_CALC);
  assign bus.stallreq_o = bus.start_i & ~bus.ready_o;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: results, latency, special cases, cancel and reset.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_unit_if bus();

  div_unit #(.DIV_CYCLES(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle at a time until ready_o, sampling on the falling edge.
  task automatic wait_ready(input logic scramble, output int lat,
                            output logic busy_seen, output logic stall_ok);
    lat = 0; busy_seen = 1'b0; stall_ok = 1'b1;
    while (1) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (bus.busy_o) busy_seen = 1'b1;
      if (bus.ready_o || lat >= 100) break;
      if (!bus.stallreq_o) stall_ok = 1'b0;
      if (scramble) begin
        bus.dividend_i = $urandom;
        bus.divisor_i  = (lat == 1) ? 32'd0 : $urandom;
      end
    end
  endtask

  task automatic run_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat; logic busy_seen, stall_ok;
    bus.start_i = 1'b1; bus.op_i = op; bus.dividend_i = a; bus.divisor_i = b;
    wait_ready(1'b1, lat, busy_seen, stall_ok);
    check({tag, " ready"},    32'(bus.ready_o), 32'd1);
    check({tag, " result"},   bus.result_o, exp);
    check({tag, " latency"},  32'(lat), 32'(exp_lat));
    check({tag, " busy"},     32'(busy_seen), 32'(exp_lat > 1));
    check({tag, " stall"},    32'(stall_ok), 32'd1);
    check({tag, " stall_done"}, 32'(bus.stallreq_o), 32'd0);
    bus.start_i = 1'b0;
    @(posedge clk); @(negedge clk);
    check({tag, " post_ready"},  32'(bus.ready_o), 32'd0);
    check({tag, " post_result"}, bus.result_o, 32'd0);
  endtask

  initial begin
    int lat, t1, t2;
    logic busy_seen, stall_ok, ready_seen;
    bus.start_i = 1'b0; bus.op_i = DIV_OP_DIVU; bus.dividend_i = '0;
    bus.divisor_i = '0; bus.cancel_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst result", bus.result_o, 32'd0);
    check("rst ready",  32'(bus.ready_o), 32'd0);
    check("rst busy",   32'(bus.busy_o), 32'd0);
    check("rst stall",  32'(bus.stallreq_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_div("divu_100_7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_div("remu_100_7", DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    run_div("div_m7_2",   DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_div("rem_m7_2",   DIV_OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_div("div_7_m2",   DIV_OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_div("rem_7_m2",   DIV_OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_div("div_5_0",    DIV_OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_div("rem_5_0",    DIV_OP_REM,  32'd5, 32'd0, 32'd5, 1);
    run_div("divu_5_0",   DIV_OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_div("div_ovf",    DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_div("rem_ovf",    DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

    // Cancel in CALC cycle 10.
    bus.start_i = 1'b1; bus.op_i = DIV_OP_DIVU; bus.dividend_i = 32'd1000; bus.divisor_i = 32'd3;
    repeat (10) begin @(posedge clk); @(negedge clk); end
    check("cancel pre_busy", 32'(bus.busy_o), 32'd1);
    bus.cancel_i = 1'b1; bus.start_i = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.cancel_i = 1'b0;
    check("cancel busy",  32'(bus.busy_o), 32'd0);
    check("cancel ready", 32'(bus.ready_o), 32'd0);
    ready_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (bus.ready_o || bus.busy_o) ready_seen = 1'b1;
    end
    check("cancel no_ready", 32'(ready_seen), 32'd0);
    run_div("divu_ffff_10", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33);

    // Reset mid-CALC.
    bus.start_i = 1'b1; bus.op_i = DIV_OP_DIVU; bus.dividend_i = 32'd100; bus.divisor_i = 32'd7;
    repeat (5) begin @(posedge clk); @(negedge clk); end
    rst = 1'b0; bus.start_i = 1'b0;
    @(posedge clk); @(negedge clk);
    check("midrst result", bus.result_o, 32'd0);
    check("midrst ready",  32'(bus.ready_o), 32'd0);
    check("midrst busy",   32'(bus.busy_o), 32'd0);
    check("midrst stall",  32'(bus.stallreq_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Back-to-back with start_i held across the DONE cycle.
    bus.start_i = 1'b1; bus.op_i = DIV_OP_DIVU; bus.dividend_i = 32'd9; bus.divisor_i = 32'd3;
    wait_ready(1'b0, lat, busy_seen, stall_ok);
    t1 = cyc;
    check("b2b first ready",  32'(bus.ready_o), 32'd1);
    check("b2b first result", bus.result_o, 32'd3);
    bus.op_i = DIV_OP_REMU; bus.dividend_i = 32'd9; bus.divisor_i = 32'd4;
    wait_ready(1'b0, lat, busy_seen, stall_ok);
    t2 = cyc;
    check("b2b second ready",  32'(bus.ready_o), 32'd1);
    check("b2b second result", bus.result_o, 32'd1);
    check("b2b spacing",       32'(t2 - t1), 32'd34);
    check("b2b stall",         32'(stall_ok), 32'd1);
    bus.start_i = 1'b0;
    @(posedge clk); @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divider serving the execute stage. When `exe` decodes DIV, DIVU, REM or REMU, it hands the operands here. The unit computes one quotient bit per cycle and raises a stall request to `pipe_ctrl` until the result is ready. It returns the 32-bit result to `exe`, which drives it onto `exe_reg_wdata_o` toward `exe_mem`.

## Interface
Parameters:
- `DIV_CYCLES`, default 32: number of iteration cycles; must equal the operand width.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset. One clock; reset is synchronous and active-low.
- `start_i`  in  1  from exe: divide instruction is in execute. Held high while exe is stalled.
- `op_i`  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `dividend_i`  in  32  rs1 value.
- `divisor_i`  in  32  rs2 value.
- `cancel_i`  in  1  from `pipe_ctrl` `flush_jump_o`: abort the current operation.
- `result_o`  out  32  quotient or remainder; valid only while `ready_o`=1, otherwise 0.
- `ready_o`  out  1  one-cycle result-valid pulse.
- `busy_o`  out  1  high in CALC.
- `stallreq_o`  out  1  to `pipe_ctrl` `stallreq_from_exe_i`.

## Operation
States:
- IDLE
  - `start_i`=1 and `cancel_i`=0: latch operands and op.
  - If divisor=0 → DONE; otherwise → CALC with the counter cleared.
- CALC
  - Each cycle: shift the partial remainder left by 1 and bring in the next dividend bit (MSB first).
  - Trial-subtract |divisor| with a 33-bit subtractor. If the result is non-negative, keep it and shift a 1 into the quotient; otherwise shift a 0.
  - After `DIV_CYCLES` iterations → DONE.
- DONE
  - `ready_o`=1 and `result_o` is driven.
  - Always → IDLE on the next edge. A new `start_i` is accepted only from IDLE.

Signed operations (DIV, REM):
- Magnitudes are taken at latch time.
- The quotient is negated if the operand signs differ.
- The remainder takes the sign of the dividend.
- Fix-up is applied when entering DONE.

Special cases (RISC-V spec):
- Divide by zero: quotient 0xFFFFFFFF for both DIV and DIVU; remainder = dividend.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.

Input handling:
- Operand inputs are ignored outside IDLE; changes during CALC have no effect.
- `stallreq_o` = `start_i` & ~`ready_o` (combinational), so exe stalls from the cycle it presents the divide until the DONE cycle.

## Timing
- Reset (`rst_i`=0 at an edge): state → IDLE, counter and datapath registers → 0. `result_o`=0, `ready_o`=0, `busy_o`=0.
  - `stallreq_o` follows its equation, so it is 0 whenever exe holds `start_i` low.
  - Reset mid-CALC discards the operation.
- Normal latency: `start_i` seen in IDLE at edge N.
  - `busy_o` is high for cycles N+1 … N+32.
  - `ready_o` pulses in cycle N+33.
- Divide by zero: `ready_o` pulses in cycle N+1; `busy_o` never rises.
- `cancel_i` in any state → IDLE at the next edge with `ready_o`=0. A DONE result is dropped.
  - `cancel_i` has priority over `start_i` in IDLE.
- Back-to-back divides: DONE → IDLE costs one cycle. With `start_i` still high, the next operation latches in the IDLE cycle after DONE.
- No stage is added to the exe output path; `result_o` is a registered value.

## Structure
- Add to `defines.v`:
  - op encodings `DIV_OP_DIV`, `DIV_OP_DIVU`, `DIV_OP_REM`, `DIV_OP_REMU`
  - state encodings `DIV_IDLE`, `DIV_CALC`, `DIV_DONE`
  - `DIV_CYCLES`
- Flat module; no sub-module is warranted. Sign handling and the restoring iteration are inline.
- Top-level integration:
  - `exe` instantiates `div_unit`.
  - `exe_stallreq_o` connects to `stallreq_o`.
  - `ctrl_flush_jump_o` connects to `cancel_i`.

## Test plan
- DIVU 100/7 → `result_o`=14 with `ready_o` at start+33. REMU 100/7 → 2.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIV 7/−2 → 0xFFFFFFFD, REM → 1.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with `ready_o` at start+1 and `busy_o` never high.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- `cancel_i` pulsed in CALC cycle 10 → `busy_o`=0 next cycle and no `ready_o`. Then DIVU 0xFFFFFFFF/0x10 → 0x0FFFFFFF.
- `rst_i` low for one edge mid-CALC → all outputs 0 next cycle. Then back-to-back DIVU 9/3, REMU 9/4 with `start_i` held → results 3 then 1, with the ready pulses 34 cycles apart.
